// File: rtl/nv_nvdla_pdp_wdma_packer.sv
// PDP write-DMA packer: turns pooled atoms into MCIF write cmd/data packets and raises done.
// Optional PDP_WDMA_PERF_EN adds a saturating downstream-stall counter output.
module nv_nvdla_pdp_wdma_packer #(
  parameter int MAX_BURST = 8,
  parameter int AW        = 64,
  parameter int DW        = 256
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rst,
  input  logic          op_en,
  input  logic [AW-1:0] cfg_dst_base_addr,
  input  logic [31:0]   cfg_line_stride,
  input  logic [12:0]   cfg_width,
  input  logic [12:0]   cfg_height,
  input  logic          dp2wdma_valid,
  output logic          dp2wdma_ready,
  input  logic [DW-1:0] dp2wdma_pd,
  output logic          pdp2mcif_wr_req_valid,
  input  logic          pdp2mcif_wr_req_ready,
  output logic [DW+1:0] pdp2mcif_wr_req_pd,
  input  logic          mcif2pdp_wr_rsp_complete,
  output logic [1:0]    pdp2glb_done_intr_pd,
  output logic          busy
`ifdef PDP_WDMA_PERF_EN
  ,
  output logic [31:0]   perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT_ACK} state_t;

  localparam logic [13:0] MAX_BURST_W = 14'(MAX_BURST);

  state_t        state_q, state_d;
  logic          valid_q, valid_d;
  logic [DW+1:0] pd_q, pd_d;
  logic          busy_q, busy_d;
  logic [1:0]    intr_q, intr_d;
  logic          ptr_q, ptr_d;
  logic          ack_seen_q, ack_seen_d;
  logic [AW-1:0] line_base_q, line_base_d;
  logic [31:0]   stride_q, stride_d;
  logic [12:0]   width_q, width_d;
  logic [12:0]   height_q, height_d;
  logic [12:0]   atom_idx_q, atom_idx_d;
  logic [12:0]   line_idx_q, line_idx_d;
  logic [12:0]   beat_q, beat_d;
  logic [12:0]   size_q, size_d;

  logic          load_ok;
  logic          in_hs;
  logic [13:0]   remaining;
  logic [13:0]   burst_len;
  logic [12:0]   burst_size;
  logic          burst_end;
  logic          line_end;
  logic          layer_end;
  logic          final_burst;
  logic [AW-1:0] cmd_addr;
  logic [DW+1:0] cmd_pd;
  logic          done;

  // The output register can take a new packet when empty or being drained this cycle.
  assign load_ok     = !valid_q || pdp2mcif_wr_req_ready;
  assign in_hs       = (state_q == DATA) && load_ok && dp2wdma_valid;
  assign remaining   = {1'b0, width_q} - {1'b0, atom_idx_q} + 14'd1;
  assign burst_len   = (remaining > MAX_BURST_W) ? MAX_BURST_W : remaining;
  assign burst_size  = 13'(burst_len - 14'd1);
  assign burst_end   = (beat_q == size_q);
  assign line_end    = (atom_idx_q == width_q);
  assign layer_end   = burst_end && line_end && (line_idx_q == height_q);
  assign final_burst = (line_idx_q == height_q) && (remaining <= MAX_BURST_W);
  assign cmd_addr    = line_base_q + {{(AW-18){1'b0}}, atom_idx_q, 5'b00000};
  assign done        = (state_q == WAIT_ACK) && load_ok
                       && (ack_seen_q || mcif2pdp_wr_rsp_complete);

  always_comb begin
    cmd_pd                 = '0;
    cmd_pd[AW-1:0]         = cmd_addr;
    cmd_pd[AW+12:AW]       = burst_size;
    cmd_pd[AW+13]          = final_burst;
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      pd_q        <= '0;
      busy_q      <= 1'b0;
      intr_q      <= 2'b00;
      ptr_q       <= 1'b0;
      ack_seen_q  <= 1'b0;
      line_base_q <= '0;
      stride_q    <= '0;
      width_q     <= '0;
      height_q    <= '0;
      atom_idx_q  <= '0;
      line_idx_q  <= '0;
      beat_q      <= '0;
      size_q      <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      pd_q        <= pd_d;
      busy_q      <= busy_d;
      intr_q      <= intr_d;
      ptr_q       <= ptr_d;
      ack_seen_q  <= ack_seen_d;
      line_base_q <= line_base_d;
      stride_q    <= stride_d;
      width_q     <= width_d;
      height_q    <= height_d;
      atom_idx_q  <= atom_idx_d;
      line_idx_q  <= line_idx_d;
      beat_q      <= beat_d;
      size_q      <= size_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (op_en) state_d = CMD;
      CMD:      if (load_ok) state_d = DATA;
      DATA:     if (in_hs && burst_end) state_d = layer_end ? WAIT_ACK : CMD;
      WAIT_ACK: if (done) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d       = valid_q;
    pd_d          = pd_q;
    busy_d        = busy_q;
    intr_d        = 2'b00;
    ptr_d         = ptr_q;
    ack_seen_d    = ack_seen_q;
    line_base_d   = line_base_q;
    stride_d      = stride_q;
    width_d       = width_q;
    height_d      = height_q;
    atom_idx_d    = atom_idx_q;
    line_idx_d    = line_idx_q;
    beat_d        = beat_q;
    size_d        = size_q;
    dp2wdma_ready = (state_q == DATA) && load_ok;

    if (valid_q && pdp2mcif_wr_req_ready) valid_d = 1'b0;
    if ((state_q != IDLE) && mcif2pdp_wr_rsp_complete) ack_seen_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (op_en) begin
          line_base_d = cfg_dst_base_addr;
          stride_d    = cfg_line_stride;
          width_d     = cfg_width;
          height_d    = cfg_height;
          atom_idx_d  = '0;
          line_idx_d  = '0;
          busy_d      = 1'b1;
        end
      end
      CMD: begin
        if (load_ok) begin
          valid_d = 1'b1;
          pd_d    = cmd_pd;
          size_d  = burst_size;
          beat_d  = '0;
        end
      end
      DATA: begin
        if (in_hs) begin
          valid_d = 1'b1;
          pd_d    = {2'b11, dp2wdma_pd};
          beat_d  = beat_q + 13'd1;
          if (line_end) begin
            atom_idx_d  = '0;
            line_idx_d  = line_idx_q + 13'd1;
            line_base_d = line_base_q + {{(AW-32){1'b0}}, stride_q};
          end else begin
            atom_idx_d = atom_idx_q + 13'd1;
          end
        end
      end
      WAIT_ACK: begin
        // Leaving for IDLE: pulse the ping-pong done bit and release busy.
        if (done) begin
          intr_d[ptr_q] = 1'b1;
          ptr_d         = ~ptr_q;
          busy_d        = 1'b0;
          ack_seen_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign pdp2mcif_wr_req_valid = valid_q;
  assign pdp2mcif_wr_req_pd    = pd_q;
  assign pdp2glb_done_intr_pd  = intr_q;
  assign busy                  = busy_q;

`ifdef PDP_WDMA_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst || ((state_q == IDLE) && op_en)) begin
      stall_cnt_q <= '0;
    end else if (valid_q && !pdp2mcif_wr_req_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
